// File: rtl/led_serial_rx.sv
// Serial receiver for a chain of four 8x8 LED matrix drivers: samples an
// asynchronous shift/latch interface and maintains the per-device display registers.
module led_serial_rx (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       din,
   input  logic       load,
   output logic       dout,
   input  logic [1:0] rd_dev,
   input  logic [2:0] rd_row,
   output logic [7:0] rd_data,
   output logic [3:0] rd_intensity,
   output logic       frame_strobe,
   output logic       err_short
);

   logic       sclk_s1_q, sclk_s2_q, sclk_d_q;
   logic       din_s1_q, din_s2_q;
   logic       load_s1_q, load_s2_q, load_d_q;
   logic       sclk_rise, load_rise, load_fall, shift_en, frame_ok;

   logic [63:0] shreg_q;
   logic [6:0]  bit_cnt_q;
   logic        dout_q;

   logic [7:0] row_q        [4][8];
   logic [3:0] intensity_q  [4];
   logic [7:0] decode_unused[4];  // held for completeness; no datapath consumes it
   logic [2:0] scan_limit_q [4];
   logic       shutdown_n_q [4];
   logic       test_q       [4];
   logic       frame_strobe_q, err_short_q;

   logic [3:0] w_addr [4];
   logic [7:0] w_data [4];
   logic [2:0] w_row  [4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_s1_q <= 1'b0;
         sclk_s2_q <= 1'b0;
         sclk_d_q  <= 1'b0;
         din_s1_q  <= 1'b0;
         din_s2_q  <= 1'b0;
         load_s1_q <= 1'b0;
         load_s2_q <= 1'b0;
         load_d_q  <= 1'b0;
      end else begin
         sclk_s1_q <= sclk;
         sclk_s2_q <= sclk_s1_q;
         sclk_d_q  <= sclk_s2_q;
         din_s1_q  <= din;
         din_s2_q  <= din_s1_q;
         load_s1_q <= load;
         load_s2_q <= load_s1_q;
         load_d_q  <= load_s2_q;
      end
   end

   assign sclk_rise = sclk_s2_q & ~sclk_d_q;
   assign load_rise = load_s2_q & ~load_d_q;
   assign load_fall = ~load_s2_q & load_d_q;
   // Gating on the synchronized load also blocks a shift coinciding with a load rise.
   assign shift_en  = sclk_rise & ~load_s2_q;
   assign frame_ok  = (bit_cnt_q == 7'd64);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q   <= 64'd0;
         bit_cnt_q <= 7'd0;
         dout_q    <= 1'b0;
      end else begin
         if (shift_en) begin
            shreg_q <= {shreg_q[62:0], din_s2_q};
            dout_q  <= shreg_q[62];
         end
         if (load_fall) begin
            bit_cnt_q <= shift_en ? 7'd1 : 7'd0;
         end else if (shift_en && !frame_ok) begin
            bit_cnt_q <= bit_cnt_q + 7'd1;
         end
      end
   end

   assign dout = dout_q;

   // Device k owns word k; device 0 holds the last 16 bits shifted in.
   always_comb begin
      for (int d = 0; d < 4; d++) begin
         w_addr[d] = shreg_q[16*d+8 +: 4];
         w_data[d] = shreg_q[16*d +: 8];
         w_row[d]  = 3'(w_addr[d] - 4'd1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 8; r++) begin
               row_q[d][r] <= 8'h00;
            end
            intensity_q[d]   <= 4'd0;
            decode_unused[d] <= 8'h00;
            scan_limit_q[d]  <= 3'd7;
            shutdown_n_q[d]  <= 1'b0;
            test_q[d]        <= 1'b0;
         end
         frame_strobe_q <= 1'b0;
         err_short_q    <= 1'b0;
      end else begin
         frame_strobe_q <= load_rise & frame_ok;
         err_short_q    <= load_rise & ~frame_ok;
         if (load_rise && frame_ok) begin
            for (int d = 0; d < 4; d++) begin
               unique case (w_addr[d])
                  4'h1, 4'h2, 4'h3, 4'h4,
                  4'h5, 4'h6, 4'h7, 4'h8: row_q[d][w_row[d]] <= w_data[d];
                  4'h9:    decode_unused[d] <= w_data[d];
                  4'hA:    intensity_q[d]   <= w_data[d][3:0];
                  4'hB:    scan_limit_q[d]  <= w_data[d][2:0];
                  4'hC:    shutdown_n_q[d]  <= w_data[d][0];
                  4'hF:    test_q[d]        <= w_data[d][0];
                  default: ;
               endcase
            end
         end
      end
   end

   assign frame_strobe = frame_strobe_q;
   assign err_short    = err_short_q;

   always_comb begin
      rd_intensity = intensity_q[rd_dev];
      if (test_q[rd_dev]) begin
         rd_data = 8'hFF;
      end else if (!shutdown_n_q[rd_dev] || (rd_row > scan_limit_q[rd_dev])) begin
         rd_data = 8'h00;
      end else begin
         rd_data = row_q[rd_dev][rd_row];
      end
   end

endmodule

// File: tb/tb_led_serial_rx.sv
// Randomized bench for led_serial_rx: drives frames over the slow serial interface and
// compares every cycle against an event-level model of the display registers.
module tb_led_serial_rx;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk  = 1'b0;
   logic       din   = 1'b0;
   logic       load  = 1'b0;
   logic [1:0] rd_dev = 2'd0;
   logic [2:0] rd_row = 3'd0;
   logic       dout;
   logic [7:0] rd_data;
   logic [3:0] rd_intensity;
   logic       frame_strobe;
   logic       err_short;

   led_serial_rx dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sclk         (sclk),
      .din          (din),
      .load         (load),
      .dout         (dout),
      .rd_dev       (rd_dev),
      .rd_row       (rd_row),
      .rd_data      (rd_data),
      .rd_intensity (rd_intensity),
      .frame_strobe (frame_strobe),
      .err_short    (err_short)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int n_strobe = 0;
   int n_err    = 0;
   bit rd_rand  = 1'b1;

   // Model state and scheduled events (cycle at which the DUT must reflect them).
   logic [63:0] m_shreg;
   int          m_cnt;
   logic [7:0]  m_row  [4][8];
   logic [3:0]  m_int  [4];
   logic [2:0]  m_scan [4];
   logic        m_shdn [4];
   logic        m_test [4];
   int          shift_due = -1;
   int          fall_due  = -1;
   int          rise_due  = -1;
   logic        shift_bit = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic void m_reset();
      m_shreg = 64'd0;
      m_cnt   = 0;
      for (int d = 0; d < 4; d++) begin
         for (int r = 0; r < 8; r++) m_row[d][r] = 8'h00;
         m_int[d]  = 4'd0;
         m_scan[d] = 3'd7;
         m_shdn[d] = 1'b0;
         m_test[d] = 1'b0;
      end
   endfunction

   function automatic void m_commit();
      logic [15:0] w;
      int a;
      for (int d = 0; d < 4; d++) begin
         w = m_shreg[16*d +: 16];
         a = int'(w[11:8]);
         if (a >= 1 && a <= 8) m_row[d][a-1] = w[7:0];
         else if (a == 10)     m_int[d]  = w[3:0];
         else if (a == 11)     m_scan[d] = w[2:0];
         else if (a == 12)     m_shdn[d] = w[0];
         else if (a == 15)     m_test[d] = w[0];
      end
   endfunction

   function automatic logic [7:0] exp_rd(input int d, input int r);
      if (m_test[d]) return 8'hFF;
      if (!m_shdn[d]) return 8'h00;
      if (r > int'(m_scan[d])) return 8'h00;
      return m_row[d][r];
   endfunction

   // Compare process: advance the model, then check every output.
   initial begin
      logic exp_strobe, exp_err;
      m_reset();
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         exp_strobe = 1'b0;
         exp_err    = 1'b0;
         if (!rst_n) begin
            m_reset();
            shift_due = -1;
            fall_due  = -1;
            rise_due  = -1;
         end else begin
            if (cyc == shift_due) begin
               m_shreg = {m_shreg[62:0], shift_bit};
               if (m_cnt < 64) m_cnt++;
            end
            if (cyc == fall_due) m_cnt = 0;
            if (cyc == rise_due) begin
               exp_strobe = (m_cnt == 64);
               exp_err    = !exp_strobe;
               if (exp_strobe) m_commit();
            end
         end
         if (frame_strobe === 1'b1) n_strobe++;
         if (err_short === 1'b1) n_err++;
         check("frame_strobe", 32'(frame_strobe), 32'(exp_strobe));
         check("err_short", 32'(err_short), 32'(exp_err));
         check("dout", 32'(dout), 32'(m_shreg[63]));
         check("rd_data", 32'(rd_data), 32'(exp_rd(int'(rd_dev), int'(rd_row))));
         check("rd_intensity", 32'(rd_intensity), 32'(m_int[rd_dev]));
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rd_rand) begin
            rd_dev = 2'($urandom_range(0, 3));
            rd_row = 3'($urandom_range(0, 7));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic send_bit(input logic b);
      din = b;
      tick(4);
      sclk = 1'b1;
      if (!load) begin
         shift_bit = b;
         shift_due = cyc + 3;
      end
      tick(4);
      sclk = 1'b0;
   endtask

   task automatic send_bits(input logic [127:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic start_frame();
      if (load) begin
         load = 1'b0;
         fall_due = cyc + 3;
         tick(4);
      end
   endtask

   task automatic end_frame();
      tick(4);
      load = 1'b1;
      rise_due = cyc + 3;
      tick(5);
   endtask

   task automatic frame64(input logic [63:0] v);
      start_frame();
      send_bits({64'd0, v}, 64);
      end_frame();
   endtask

   function automatic logic [63:0] rep4(input logic [15:0] w);
      return {w, w, w, w};
   endfunction

   task automatic lit(input string name, input int d, input int r, input logic [7:0] exp);
      rd_rand = 1'b0;
      rd_dev  = 2'(d);
      rd_row  = 3'(r);
      #1;
      check(name, 32'(rd_data), 32'(exp));
   endtask

   task automatic lit_int(input string name, input int d, input logic [3:0] exp);
      rd_rand = 1'b0;
      rd_dev  = 2'(d);
      #1;
      check(name, 32'(rd_intensity), 32'(exp));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int s0, e0, nb;
      logic [127:0] rv;
      logic [15:0] w [4];
      tick(4);
      check("reset rd_data", 32'(rd_data), 32'h00);
      check("reset dout", 32'(dout), 32'h0);
      rst_n = 1'b1;
      tick(3);

      // Enable every device; rows remain empty.
      s0 = n_strobe;
      e0 = n_err;
      frame64(rep4(16'h0C01));
      check("enable strobe count", 32'(n_strobe - s0), 32'd1);
      check("enable err count", 32'(n_err - e0), 32'd0);
      lit("enable row empty", 0, 0, 8'h00);
      lit_int("enable intensity", 0, 4'd0);

      // Device 0 gets the last word shifted in.
      frame64({16'h0155, 16'h0000, 16'h0000, 16'h01AA});
      lit("dev0 row0", 0, 0, 8'hAA);
      lit("dev3 row0", 3, 0, 8'h55);
      lit("dev1 row0", 1, 0, 8'h00);

      // Short frame: rejected, nothing changes.
      s0 = n_strobe;
      e0 = n_err;
      start_frame();
      send_bits({$urandom, $urandom, $urandom, $urandom}, 48);
      end_frame();
      check("short strobe count", 32'(n_strobe - s0), 32'd0);
      check("short err count", 32'(n_err - e0), 32'd1);
      lit("short keeps dev0", 0, 0, 8'hAA);
      lit("short keeps dev3", 3, 0, 8'h55);

      // Scan limit and test mode.
      frame64(rep4(16'h0B02));
      frame64(rep4(16'h05FF));
      frame64(rep4(16'h033C));
      lit("row4 beyond scan", 1, 4, 8'h00);
      lit("row2 within scan", 1, 2, 8'h3C);
      lit("row0 within scan", 0, 0, 8'hAA);
      frame64(rep4(16'h0F01));
      lit("test row4", 1, 4, 8'hFF);
      lit("test row7", 2, 7, 8'hFF);
      frame64(rep4(16'h0F00));
      frame64(rep4(16'h0B07));
      lit("row4 after scan 7", 1, 4, 8'hFF);

      // 80 bits: first 16 fall out of dout, last 64 commit.
      rv = {48'd0, 16'hC3A5, rep4(16'h0A07)};
      start_frame();
      send_bits(rv >> 16, 64);
      check("dout after 64 shifts", 32'(dout), 32'h1);
      send_bits(rv, 16);
      end_frame();
      lit_int("80-bit intensity", 2, 4'd7);

      // Reset mid-frame discards the partial frame.
      start_frame();
      send_bits({$urandom, $urandom, $urandom, $urandom}, 30);
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      frame64(rep4(16'h0A09));
      lit_int("post-reset intensity", 0, 4'd9);
      lit("post-reset shutdown", 0, 0, 8'h00);
      frame64(rep4(16'h0C01));
      frame64(rep4(16'h0811));
      lit("post-reset row7", 2, 7, 8'h11);
      lit("post-reset row4", 1, 4, 8'h00);
      rd_rand = 1'b1;

      // Random frames of mixed lengths, plus ignored sclk activity while load is high.
      repeat (40) begin
         for (int k = 0; k < 4; k++) begin
            w[k] = 16'($urandom);
            if ($urandom_range(0, 3) != 0) w[k][11:8] = 4'($urandom_range(1, 12));
            if (w[k][11:8] == 4'hF) w[k][0] = 1'b0;
         end
         nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 90)) : 64;
         rv = {$urandom, $urandom, w[3], w[2], w[1], w[0]};
         start_frame();
         send_bits(rv, nb);
         end_frame();
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) send_bit(1'($urandom));
         end
      end

      tick(10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
